// File: rtl/utmi_tx_arbiter_if.sv
// utmi_tx_arbiter_if: requester-side and UTMI-side signals of the TX arbiter
//   req/req_pid/req_len/req_data : per-requester packet request, PID, length, head byte
//   gnt/rd_en                    : one-hot grant and pop strobe back to requesters
//   tx_data/tx_valid/tx_ready    : UTMI transmit handshake
//   busy/done/err                : status (active, packet complete, watchdog abort)
interface utmi_tx_arbiter_if #(parameter int LEN_W = 7);
   logic [3:0]         req;
   logic [15:0]        req_pid;
   logic [4*LEN_W-1:0] req_len;
   logic [31:0]        req_data;
   logic [3:0]         gnt;
   logic               rd_en;
   logic [7:0]         tx_data;
   logic               tx_valid;
   logic               tx_ready;
   logic               busy;
   logic               done;
   logic               err;
   modport slave (input req, req_pid, req_len, req_data, tx_ready,
                  output gnt, rd_en, tx_data, tx_valid, busy, done, err);
   modport master (output req, req_pid, req_len, req_data, tx_ready,
                   input gnt, rd_en, tx_data, tx_valid, busy, done, err);
endinterface

// File: rtl/utmi_tx_arbiter.sv
// utmi_tx_arbiter: round-robin arbiter feeding four packet sources into one UTMI TX port
//   clk, reset : clock and synchronous active-high reset
//   bus        : utmi_tx_arbiter_if slave (requests in, grant/pop/UTMI TX/status out)
//   IPG        : idle cycles between packets (1..15); LEN_W : length field width (>= 7)
//   TX_ARB_TIMEOUT_EN : when defined, a stall of 255 cycles aborts the packet with err
module utmi_tx_arbiter #(
   parameter int IPG   = 2,
   parameter int LEN_W = 7
) (
   input logic              clk,
   input logic              reset,
   utmi_tx_arbiter_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_PID, S_DATA, S_GAP} state_t;
   state_t           r_state;
   logic [1:0]       r_ptr, r_idx, w_sel;
   logic [LEN_W-1:0] r_cnt, w_len;
   logic [3:0]       r_pid, r_gap;
   logic             w_valid, w_acc, w_last, w_end, w_tmo;
   // scan from r_ptr upward; iterating downward lets the closest requester win
   always_comb begin
      w_sel = r_ptr;
      for (int k = 3; k >= 0; k--)
         if (bus.req[r_ptr + 2'(k)]) w_sel = r_ptr + 2'(k);
   end
   assign w_len   = bus.req_len[LEN_W*w_sel +: LEN_W];
   assign w_valid = (r_state == S_PID) || (r_state == S_DATA);
   // reset gating keeps an abandoned packet from emitting a final pop or done
   assign w_acc   = w_valid && bus.tx_ready && !reset;
   assign w_last  = (r_state == S_PID) ? (r_cnt == '0) : (r_cnt == LEN_W'(1));
   assign w_end   = w_tmo || (w_acc && w_last);
`ifdef TX_ARB_TIMEOUT_EN
   logic [7:0] r_wd;
   always_ff @(posedge clk)
      r_wd <= (reset || !w_valid || bus.tx_ready) ? 8'd0 : r_wd + 8'd1;
   // r_wd counts prior stalled cycles, so 254 marks the 255th
   assign w_tmo = w_valid && !bus.tx_ready && !reset && (r_wd == 8'd254);
`else
   assign w_tmo = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_ptr   <= 2'd0;
         r_idx   <= 2'd0;
         r_cnt   <= '0;
         r_pid   <= 4'd0;
         r_gap   <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE:
               if (|bus.req) begin
                  r_idx   <= w_sel;
                  r_ptr   <= w_sel + 2'd1;
                  r_pid   <= bus.req_pid[4*w_sel +: 4];
                  r_cnt   <= (w_len > LEN_W'(64)) ? LEN_W'(64) : w_len;
                  r_state <= S_PID;
               end
            S_PID, S_DATA:
               if (w_end) begin
                  r_state <= S_GAP;
                  r_gap   <= 4'(IPG - 1);
               end else if (w_acc) begin
                  r_state <= S_DATA;
                  r_cnt   <= (r_state == S_DATA) ? r_cnt - LEN_W'(1) : r_cnt;
               end
            default: begin
               r_state <= (r_gap == 4'd0) ? S_IDLE : S_GAP;
               r_gap   <= r_gap - 4'd1;
            end
         endcase
      end
   end
   assign bus.gnt      = w_valid ? 4'b0001 << r_idx : 4'b0000;
   assign bus.tx_valid = w_valid;
   assign bus.tx_data  = (r_state == S_PID)  ? {~r_pid, r_pid} :
                         (r_state == S_DATA) ? bus.req_data[8*r_idx +: 8] : 8'h00;
   assign bus.rd_en    = w_acc && (r_state == S_DATA);
   assign bus.done     = w_acc && w_last;
   assign bus.busy     = r_state != S_IDLE;
   assign bus.err      = w_tmo;
endmodule

// File: tb/tb_utmi_tx_arbiter.sv
// tb_utmi_tx_arbiter: directed table and sequence checks of utmi_tx_arbiter
module tb_utmi_tx_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   logic [7:0] pop [4];
   utmi_tx_arbiter_if #(.LEN_W(7)) bus ();
   utmi_tx_arbiter #(.IPG(2), .LEN_W(7)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
   always #5 clk = ~clk;
   // requester i presents bytes 0x10*(i+1)+n, advancing on each pop
   always_ff @(posedge clk)
      for (int i = 0; i < 4; i++)
         pop[i] <= reset ? 8'h00 : (bus.gnt[i] && bus.rd_en) ? pop[i] + 8'd1 : pop[i];
   always_comb bus.req_data = {pop[3] + 8'h40, pop[2] + 8'h30, pop[1] + 8'h20, pop[0] + 8'h10};
   typedef struct packed {
      logic       rst;
      logic [3:0] req;
      logic       rdy;
      logic [3:0] gnt;
      logic       rd;
      logic [7:0] data;
      logic       vld;
      logic       busy;
      logic       done;
   } vec_t;
   vec_t tbl [14];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic wait_valid(input string nm, output int idle);
      idle = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); #1;
         if (bus.tx_valid) return;
         idle++;
      end
      n_chk++;
      n_fail++;
      $display("FAIL %s: tx_valid never rose, got 0 expected 1", nm);
   endtask
   task automatic wait_done(input string nm);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); #1;
         if (bus.done) return;
      end
      n_chk++;
      n_fail++;
      $display("FAIL %s: done never pulsed, got 0 expected 1", nm);
   endtask
   initial begin
      #2000000;
      $display("FAIL global timeout");
      $fatal(1, "bench timed out");
   end
   initial begin
      int idle, pops;
      logic got;
      logic [7:0] last;
      logic [3:0] exp_g [5];
      bus.req = 4'h0;
      bus.tx_ready = 1'b1;
      bus.req_pid = {4'h7, 4'h5, 4'h2, 4'h1};
      bus.req_len = {7'd100, 7'd2, 7'd0, 7'd3};
      tbl[0]  = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 4'h1, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 4'h0, 1'b1, 4'h1, 1'b0, 8'hE1, 1'b1, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 4'h0, 1'b1, 4'h1, 1'b1, 8'h10, 1'b1, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 4'h0, 1'b1, 4'h1, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 4'h0, 1'b1, 4'h1, 1'b1, 8'h12, 1'b1, 1'b1, 1'b1};
      tbl[6]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 4'h2, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 4'h0, 1'b0, 4'h2, 1'b0, 8'hD2, 1'b1, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 4'h0, 1'b1, 4'h2, 1'b0, 8'hD2, 1'b1, 1'b1, 1'b1};
      tbl[11] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 4'h9, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      repeat (2) @(posedge clk);
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         reset = tbl[k].rst;
         bus.req = tbl[k].req;
         bus.tx_ready = tbl[k].rdy;
         #1;
         chk($sformatf("v%0d gnt", k), 32'(bus.gnt), 32'(tbl[k].gnt));
         chk($sformatf("v%0d rd_en", k), 32'(bus.rd_en), 32'(tbl[k].rd));
         chk($sformatf("v%0d tx_data", k), 32'(bus.tx_data), 32'(tbl[k].data));
         chk($sformatf("v%0d tx_valid", k), 32'(bus.tx_valid), 32'(tbl[k].vld));
         chk($sformatf("v%0d busy", k), 32'(bus.busy), 32'(tbl[k].busy));
         chk($sformatf("v%0d done", k), 32'(bus.done), 32'(tbl[k].done));
         chk($sformatf("v%0d err", k), 32'(bus.err), 32'd0);
      end
      // length 100 from requester 3 is clamped to 64 payload bytes
      @(negedge clk);
      bus.req = 4'h0;
      #1;
      chk("clamp pid gnt", 32'(bus.gnt), 32'h8);
      chk("clamp pid byte", 32'(bus.tx_data), 32'h87);
      pops = 0;
      got = 1'b0;
      last = 8'h00;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk); #1;
         if (bus.rd_en) begin
            pops++;
            last = bus.tx_data;
         end
         got = bus.done;
      end
      chk("clamp done seen", 32'(got), 32'd1);
      chk("clamp pops", 32'(pops), 32'd64);
      chk("clamp last byte", 32'(last), 32'h7F);
      // stall on the second payload byte of requester 2
      bus.req = 4'b0100;
      wait_valid("stall wait", idle);
      chk("gap+idle cycles", 32'(idle), 32'd3);
      chk("stall pid gnt", 32'(bus.gnt), 32'h4);
      chk("stall pid byte", 32'(bus.tx_data), 32'hA5);
      bus.req = 4'h0;
      @(negedge clk); #1;
      chk("stall byte0", 32'(bus.tx_data), 32'h30);
      chk("stall byte0 rd", 32'(bus.rd_en), 32'd1);
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         bus.tx_ready = 1'b0;
         #1;
         chk($sformatf("stall%0d data", s), 32'(bus.tx_data), 32'h31);
         chk($sformatf("stall%0d rd", s), 32'(bus.rd_en), 32'd0);
         chk($sformatf("stall%0d vld", s), 32'(bus.tx_valid), 32'd1);
      end
      @(negedge clk);
      bus.tx_ready = 1'b1;
      #1;
      chk("stall resume data", 32'(bus.tx_data), 32'h31);
      chk("stall resume rd", 32'(bus.rd_en), 32'd1);
      chk("stall resume done", 32'(bus.done), 32'd1);
      @(negedge clk); #1;
      chk("stall gap vld", 32'(bus.tx_valid), 32'd0);
      // without the watchdog a long stall just waits
      bus.req = 4'b0001;
      bus.tx_ready = 1'b0;
      wait_valid("long stall wait", idle);
      bus.req = 4'h0;
      repeat (300) @(negedge clk);
      #1;
      chk("long stall vld", 32'(bus.tx_valid), 32'd1);
      chk("long stall err", 32'(bus.err), 32'd0);
      chk("long stall data", 32'(bus.tx_data), 32'hE1);
      @(negedge clk);
      bus.tx_ready = 1'b1;
      #1;
      @(negedge clk); #1;
      chk("pre-reset byte", 32'(bus.tx_data), 32'h13);
      chk("pre-reset rd", 32'(bus.rd_en), 32'd1);
      // reset during the second payload byte
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("reset cyc rd", 32'(bus.rd_en), 32'd0);
      chk("reset cyc done", 32'(bus.done), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      bus.req = 4'b0100;
      #1;
      chk("post-reset outs", 32'({bus.gnt, bus.rd_en, bus.tx_data, bus.tx_valid, bus.busy, bus.done, bus.err}), 32'd0);
      @(negedge clk); #1;
      chk("post-reset gnt", 32'(bus.gnt), 32'h4);
      chk("post-reset pid", 32'(bus.tx_data), 32'hA5);
      bus.req = 4'h0;
      // all four held with length 1: rotation from requester 0
      @(negedge clk);
      reset = 1'b1;
      bus.req_len = {7'd1, 7'd1, 7'd1, 7'd1};
      bus.req = 4'hF;
      @(negedge clk);
      reset = 1'b0;
      exp_g = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
      for (int k = 0; k < 5; k++) begin
         wait_valid($sformatf("rr%0d wait", k), idle);
         chk($sformatf("rr%0d gnt", k), 32'(bus.gnt), 32'(exp_g[k]));
         if (k > 0) chk($sformatf("rr%0d idle", k), 32'(idle), 32'd3);
         wait_done($sformatf("rr%0d done", k));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/utmi_tx_arbiter.md
UTMI_TX_ARBITER -- requirements
Module: utmi_tx_arbiter

Interface
REQ-001 SHALL have parameter IPG, default 2, meaning idle cycles inserted between packets (range 1..15).
REQ-002 SHALL have parameter LEN_W, default 7, meaning per-requester payload length width (max payload 64 bytes).
REQ-003 SHALL have port clk  input  1  the single clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  4  per-requester packet-pending flag, bit i = requester i.
REQ-006 SHALL have port req_pid  input  16  4-bit PID per requester, requester i at bits [4i+3:4i].
REQ-007 SHALL have port req_len  input  4*LEN_W  payload byte count per requester, requester i at bits [LEN_W*i+LEN_W-1:LEN_W*i].
REQ-008 SHALL have port req_data  input  32  current payload byte per requester, requester i at bits [8i+7:8i].
REQ-009 SHALL have port gnt  output  4  one-hot grant, held for the whole packet.
REQ-010 SHALL have port rd_en  output  1  one-cycle pop strobe to the granted requester, one per accepted payload byte.
REQ-011 SHALL have port tx_data  output  8  byte to the UTMI transmit datapath.
REQ-012 SHALL have port tx_valid  output  1  UTMI TX_VALID, high for the whole packet.
REQ-013 SHALL have port tx_ready  input  1  UTMI TX_READY, tx_data accepted on any cycle with tx_valid and tx_ready both high.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse on the cycle the last byte of a packet is accepted.
REQ-016 SHALL have port err  output  1  one-cycle abort pulse (see Configuration).

Function
REQ-017 SHALL implement states IDLE, PID, DATA, GAP.
REQ-018 IDLE: SHALL arbitrate when req != 0, using round-robin that starts from the requester after the last one granted; gnt, the latched length and the PID register SHALL be updated on the same edge, then the block SHALL go to PID.
REQ-019 PID: SHALL drive tx_valid=1 and tx_data={~pid,pid}; on acceptance SHALL go to DATA if the length is nonzero, else go to GAP and pulse done.
REQ-020 DATA: tx_data SHALL equal the granted requester's req_data byte; on each acceptance SHALL pulse rd_en and decrement the remaining count; on acceptance of the final byte SHALL pulse done and go to GAP.
REQ-021 tx_data and tx_valid SHALL stay stable while tx_valid=1 and tx_ready=0; rd_en SHALL stay 0 in that case.
REQ-022 GAP: tx_valid and gnt SHALL be 0; SHALL hold for exactly IPG cycles, then go to IDLE; arbitration latency from IDLE with req pending SHALL be 1 cycle.
REQ-023 req changes after grant SHALL be ignored until the packet completes; a requester that drops req mid-packet SHALL still be served to the latched length.
REQ-024 A length greater than 64 SHALL be clamped to 64.
REQ-025 With a single requester held active, it SHALL be re-granted after every GAP; with all four active, grants SHALL rotate 0,1,2,3,0.

Reset
REQ-026 While reset=1, the block SHALL, at the next clk edge, set state=IDLE, gnt=0, rd_en=0, tx_data=0, tx_valid=0, busy=0, done=0, err=0, and set the round-robin pointer so that requester 0 has highest priority.
REQ-027 Reset mid-packet SHALL abandon the packet without a done pulse or an rd_en pulse.

Configuration
REQ-028 With macro TX_ARB_TIMEOUT_EN defined, an 8-bit watchdog SHALL count consecutive cycles with tx_valid=1 and tx_ready=0.
REQ-029 Watchdog behaviour: at 255 such cycles the block SHALL pulse err, drop tx_valid and gnt, and go to GAP; the watchdog SHALL clear on any acceptance.
REQ-030 With TX_ARB_TIMEOUT_EN undefined, there SHALL be no watchdog, err SHALL be tied to 0, and the block SHALL wait indefinitely for tx_ready.

Verification
REQ-031 Scenario: req=0001, pid=4'h1, len=3, tx_ready=1 constantly -> tx_data sequence 8'hE1 then three bytes; 3 rd_en pulses; done on the 4th accepted byte; tx_valid low for 2 cycles afterwards.
REQ-032 Scenario: req=1111 held, len=1 each -> gnt sequence 0001,0010,0100,1000,0001.
REQ-033 Scenario: len=0, pid=4'h2 -> single byte 8'hD2, no rd_en, done pulse.
REQ-034 Scenario: tx_ready low for 5 cycles mid-DATA -> tx_data held constant, no rd_en during the stall, byte count unchanged.
REQ-035 Scenario: reset asserted for 1 cycle during the 2nd payload byte -> next cycle all outputs 0, state IDLE; a following req=0100 is granted first.
REQ-036 Scenario (TX_ARB_TIMEOUT_EN defined): tx_ready held at 0 -> err pulse after 255 stalled cycles, tx_valid drops, block back in IDLE after IPG cycles.
